// File: rtl/inv_mix_columns.sv
// rtl/inv_mix_columns.sv - AES InvMixColumns, one column per cycle over four RUN cycles.
module inv_mix_columns (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         i_start,
  input  logic [127:0] i_data,
  output logic         o_busy,
  output logic         o_done,
  output logic [127:0] o_data
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t       state_q, state_d;
  logic [1:0]   col_q, col_d;
  logic [127:0] data_q, data_d;
  logic [31:0]  col_word;
  logic [31:0]  col_new;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Coefficients are at most 4 bits, so three doublings cover every partial product.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] c);
    logic [7:0] x1, x2, x3;
    x1 = xtime(a);
    x2 = xtime(x1);
    x3 = xtime(x2);
    return ({8{c[0]}} & a) ^ ({8{c[1]}} & x1) ^ ({8{c[2]}} & x2) ^ ({8{c[3]}} & x3);
  endfunction

  function automatic logic [31:0] inv_col(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    a0 = w[31:24];
    a1 = w[23:16];
    a2 = w[15:8];
    a3 = w[7:0];
    return {gmul(a0, 4'hE) ^ gmul(a1, 4'hB) ^ gmul(a2, 4'hD) ^ gmul(a3, 4'h9),
            gmul(a0, 4'h9) ^ gmul(a1, 4'hE) ^ gmul(a2, 4'hB) ^ gmul(a3, 4'hD),
            gmul(a0, 4'hD) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'hE) ^ gmul(a3, 4'hB),
            gmul(a0, 4'hB) ^ gmul(a1, 4'hD) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'hE)};
  endfunction

  always_comb begin
    col_word = 32'h0;
    case (col_q)
      2'd0:    col_word = data_q[127:96];
      2'd1:    col_word = data_q[95:64];
      2'd2:    col_word = data_q[63:32];
      default: col_word = data_q[31:0];
    endcase
  end

  assign col_new = inv_col(col_word);

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          data_d  = i_data;
          col_d   = 2'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        case (col_q)
          2'd0:    data_d[127:96] = col_new;
          2'd1:    data_d[95:64]  = col_new;
          2'd2:    data_d[63:32]  = col_new;
          default: data_d[31:0]   = col_new;
        endcase
        // Counter wraps 3->0 on the last column, leaving it ready for the next load.
        col_d = col_q + 2'd1;
        if (col_q == 2'd3) state_d = DONE;
      end
      DONE: begin
        if (i_start) begin
          data_d  = i_data;
          col_d   = 2'd0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      col_q   <= 2'd0;
      data_q  <= 128'h0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      data_q  <= data_d;
    end
  end

  assign o_busy = (state_q == RUN);
  assign o_done = (state_q == DONE);
  assign o_data = data_q;

endmodule

// File: tb/tb_inv_mix_columns.sv
// tb/tb_inv_mix_columns.sv - directed and round-trip scoreboard bench for inv_mix_columns.
module tb_inv_mix_columns;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         i_start;
  logic [127:0] i_data;
  logic         o_busy;
  logic         o_done;
  logic [127:0] o_data;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int done_cnt = 0;
  int t1, t2, saved;
  logic [127:0] exp_q[$];

  localparam logic [127:0] V1_IN  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] V1_OUT = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] V2_IN  = 128'h4d7ebdf8_d5d5d7d6_00000000_ffffffff;
  localparam logic [127:0] V2_OUT = 128'h2d26314c_d4d4d4d5_00000000_ffffffff;

  inv_mix_columns dut (
    .clk     (clk),
    .n_rst   (n_rst),
    .i_start (i_start),
    .i_data  (i_data),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_data  (o_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] fwd_col(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    a0 = w[31:24];
    a1 = w[23:16];
    a2 = w[15:8];
    a3 = w[7:0];
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

  function automatic logic [127:0] fwd_mix(input logic [127:0] s);
    return {fwd_col(s[127:96]), fwd_col(s[95:64]), fwd_col(s[63:32]), fwd_col(s[31:0])};
  endfunction

  // Scoreboard: every done pulse consumes the oldest expected result.
  always @(negedge clk) begin
    if (o_done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) chk("unexpected_done", {127'h0, o_done}, 128'h0);
      else chk("result", o_data, exp_q.pop_front());
    end
  end

  // Called at a negedge; drives a start now and checks the 4 RUN cycles and the DONE cycle.
  task automatic run_vec(input logic [127:0] d, input logic [127:0] e, input bit disturb);
    i_start = 1'b1;
    i_data  = d;
    exp_q.push_back(e);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      i_start = 1'b0;
      if (disturb) begin
        i_data = {$urandom(), $urandom(), $urandom(), $urandom()};
        if (k == 1) i_start = 1'b1;
      end
      chk("busy_run", {127'h0, o_busy}, 128'h1);
      chk("done_run", {127'h0, o_done}, 128'h0);
    end
    @(negedge clk);
    i_start = 1'b0;
    chk("done_pulse", {127'h0, o_done}, 128'h1);
    chk("busy_done", {127'h0, o_busy}, 128'h0);
  endtask

  initial begin
    logic [127:0] s;
    n_rst   = 1'b0;
    i_start = 1'b0;
    i_data  = V1_IN;
    #3;
    chk("reset_busy", {127'h0, o_busy}, 128'h0);
    chk("reset_done", {127'h0, o_done}, 128'h0);
    chk("reset_data", o_data, 128'h0);

    @(negedge clk);
    n_rst = 1'b1;
    run_vec(V1_IN, V1_OUT, 1'b0);
    repeat (2) @(negedge clk);
    chk("hold_data", o_data, V1_OUT);
    chk("idle_busy", {127'h0, o_busy}, 128'h0);

    @(negedge clk);
    run_vec(V2_IN, V2_OUT, 1'b0);
    @(negedge clk);

    @(negedge clk);
    run_vec(V1_IN, V1_OUT, 1'b1);
    @(negedge clk);

    // Back-to-back: i_start held through RUN, second vector applied in DONE.
    @(negedge clk);
    i_start = 1'b1;
    i_data  = V2_IN;
    exp_q.push_back(V2_OUT);
    repeat (4) begin
      @(negedge clk);
      chk("b2b_busy_a", {127'h0, o_busy}, 128'h1);
    end
    @(negedge clk);
    chk("b2b_done_a", {127'h0, o_done}, 128'h1);
    t1 = cyc;
    i_data = V1_IN;
    exp_q.push_back(V1_OUT);
    @(negedge clk);
    i_start = 1'b0;
    chk("b2b_no_idle", {127'h0, o_busy}, 128'h1);
    repeat (3) begin
      @(negedge clk);
      chk("b2b_busy_b", {127'h0, o_busy}, 128'h1);
    end
    @(negedge clk);
    chk("b2b_done_b", {127'h0, o_done}, 128'h1);
    t2 = cyc;
    chk("b2b_spacing", 128'(t2 - t1), 128'd5);
    @(negedge clk);

    // Reset asserted while column 2 is active.
    @(negedge clk);
    i_start = 1'b1;
    i_data  = V2_IN;
    @(negedge clk);
    i_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    n_rst = 1'b0;
    #1;
    chk("abort_busy", {127'h0, o_busy}, 128'h0);
    chk("abort_done", {127'h0, o_done}, 128'h0);
    chk("abort_data", o_data, 128'h0);
    saved = done_cnt;
    @(negedge clk);
    n_rst = 1'b1;
    repeat (8) @(negedge clk);
    chk("abort_no_done", 128'(done_cnt), 128'(saved));
    chk("abort_idle", {127'h0, o_busy}, 128'h0);

    for (int v = 0; v < 1000; v++) begin
      s = {$urandom(), $urandom(), $urandom(), $urandom()};
      @(negedge clk);
      run_vec(fwd_mix(s), s, 1'b0);
    end
    @(negedge clk);

    chk("queue_drained", 128'(exp_q.size()), 128'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
